simd_issue_ctrl: RTL and testbench
==================================

SIMD_ISSUE_CTRL -- requirements
Module: simd_issue_ctrl

Interface
REQ-001 SHALL have parameter INS_ADDR_WIDTH, default 8, instruction memory address width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, data memory address width.
REQ-003 SHALL have parameter OPCODE_WIDTH, default 3, opcode field width.
REQ-004 SHALL have parameter OP_SEL_WIDTH, default 2, PE operation select width.
REQ-005 SHALL have parameter INS_WIDTH, default 64, instruction word width.
REQ-006 SHALL use one clock and a synchronous, active-low reset: clk input 1, rising-edge clock; rstn input 1, synchronous active-low reset.
REQ-007 SHALL have the following ports:
- start input 1: begin program execution at address 0.
- ins_data input INS_WIDTH: instruction memory read data, valid one cycle after ins_addr.
- ins_addr output INS_ADDR_WIDTH: instruction memory read address (program counter).
- a_addr, b_addr output ADDR_WIDTH each: operand A and B addresses.
- r_addr output ADDR_WIDTH: result write address.
- pe_op output OP_SEL_WIDTH: PE operation select.
- dot_prod_en output 1: PE accumulate enable.
- shift output 1: operand shift strobe.
- write_en output 1: result write strobe.
- r_select output 1: result source, 0 = PE output, 1 = dot-product accumulator.
- busy output 1: program executing.
- done output 1: one-cycle pulse on program completion.
- pc_overflow output 1: program ran off the end of instruction memory; sticky until next start.

Function
REQ-008 SHALL decode the instruction word as follows; all other bits are ignored:
- opcode = ins_data[63:61]
- r = [59:50]
- a = [49:40]
- b = [39:30]
- cnt = [29:22]
REQ-009 SHALL decode opcodes as: 000 NOP, 001 ADD (pe_op 00), 010 SUB (pe_op 01), 011 MUL (pe_op 10), 100 DOT, 111 HALT; 101 and 110 are executed as NOP.
REQ-010 SHALL implement FSM states IDLE, FETCH, DECODE, EXEC, DOT, WRITE, DONE.
REQ-011 IDLE: when start=1, SHALL clear pc and pc_overflow, then go to FETCH; otherwise remain in IDLE.
REQ-012 FETCH: SHALL drive ins_addr=pc and go to DECODE.
REQ-013 DECODE: SHALL register the fields, then branch:
- HALT -> DONE, pc unchanged.
- NOP -> FETCH, pc+1.
- ADD/SUB/MUL -> EXEC, pc+1.
- DOT -> DOT, pc+1, loading the counter with cnt (cnt=0 treated as 1).
REQ-014 EXEC: SHALL drive a_addr, b_addr and pe_op from the registered fields for exactly 1 cycle, then go to WRITE.
REQ-015 DOT: SHALL assert dot_prod_en=1 and shift=1 and drive a_addr and b_addr every cycle; SHALL decrement the counter; SHALL go to WRITE after exactly max(cnt,1) cycles.
REQ-016 WRITE: SHALL assert write_en=1 for exactly 1 cycle with r_addr = the registered r field; r_select=1 if the instruction was DOT, else 0; then go to FETCH.
REQ-017 DONE: SHALL assert done=1 for 1 cycle, then go to IDLE.
REQ-018 busy SHALL be 1 in every state except IDLE and DONE.
REQ-019 Outside its asserting state, each of write_en, dot_prod_en, shift and done SHALL be 0; the address outputs hold their last value.
REQ-020 Latency: per-instruction cycles SHALL be NOP 2, ADD/SUB/MUL 4, DOT 3+max(cnt,1), HALT 2, with DONE adding 1 more cycle.
REQ-021 PC wrap: if a non-HALT instruction is decoded at pc = 2^INS_ADDR_WIDTH-1, that instruction SHALL complete, then pc_overflow is set and the FSM goes to DONE instead of FETCH.
REQ-022 start SHALL be ignored while busy=1 and during DONE.

Reset
REQ-023 When rstn=0 at a rising clk edge, the block SHALL go to IDLE with pc=0, counter=0, all outputs 0 and pc_overflow=0, regardless of the current state.
REQ-024 Reset mid-instruction SHALL abort immediately, with no write_en pulse on the following cycle.

Verification
REQ-025 Program {ADD r=5 a=1 b=2, HALT}, start pulse: expected response is
- EXEC with a_addr=1, b_addr=2, pe_op=00;
- then write_en=1, r_addr=5, r_select=0;
- done pulse 7 cycles after start is sampled, busy=0 afterwards.
REQ-026 DOT cnt=4 r=9 a=0 b=16: expected response is shift=1 and dot_prod_en=1 for exactly 4 consecutive cycles, then a single write_en with r_addr=9 and r_select=1.
REQ-027 DOT cnt=0: expected response is exactly 1 shift cycle, then a write.
REQ-028 Opcodes 101, 110 and 000 followed by HALT: expected response is no write_en, no shift and pe_op unchanged; done at 2+2+2+2+1 cycles.
REQ-029 Memory filled with NOP, no HALT: expected response is pc reaching 255, then pc_overflow=1 and a done pulse; the next start clears pc_overflow.
REQ-030 rstn=0 asserted during a DOT counting cycle: expected response is shift=0 and busy=0 on the next cycle; a start pulse reasserted during busy is ignored (pc not reset).

Source files
------------

// File: rtl/simd_issue_ctrl.sv
// Sequencer for a SIMD processing-element array: fetches 64-bit instructions,
// decodes them and steps operand/result addresses and PE strobes.
module simd_issue_ctrl #(
   parameter int INS_ADDR_WIDTH = 8,
   parameter int ADDR_WIDTH     = 10,
   parameter int OPCODE_WIDTH   = 3,
   parameter int OP_SEL_WIDTH   = 2,
   parameter int INS_WIDTH      = 64
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      start,
   input  logic [INS_WIDTH-1:0]      ins_data,
   output logic [INS_ADDR_WIDTH-1:0] ins_addr,
   output logic [ADDR_WIDTH-1:0]     a_addr,
   output logic [ADDR_WIDTH-1:0]     b_addr,
   output logic [ADDR_WIDTH-1:0]     r_addr,
   output logic [OP_SEL_WIDTH-1:0]   pe_op,
   output logic                      dot_prod_en,
   output logic                      shift,
   output logic                      write_en,
   output logic                      r_select,
   output logic                      busy,
   output logic                      done,
   output logic                      pc_overflow,
   output logic [2:0]                dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_DOT    = 3'd4,
      S_WRITE  = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 3'b001;
   localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 3'b010;
   localparam logic [OPCODE_WIDTH-1:0] OP_MUL  = 3'b011;
   localparam logic [OPCODE_WIDTH-1:0] OP_DOT  = 3'b100;
   localparam logic [OPCODE_WIDTH-1:0] OP_HALT = 3'b111;
   localparam logic [INS_ADDR_WIDTH-1:0] PC_LAST = '1;

   state_t                    state_q, state_d;
   logic [INS_ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [7:0]                cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]     r_f_q, r_f_d;
   logic                      is_dot_q, is_dot_d;
   logic                      last_q, last_d;
   logic [ADDR_WIDTH-1:0]     a_addr_q, a_addr_d;
   logic [ADDR_WIDTH-1:0]     b_addr_q, b_addr_d;
   logic [ADDR_WIDTH-1:0]     r_addr_q, r_addr_d;
   logic [OP_SEL_WIDTH-1:0]   pe_op_q, pe_op_d;
   logic                      pc_overflow_q, pc_overflow_d;

   logic [OPCODE_WIDTH-1:0]   dec_op;
   logic [ADDR_WIDTH-1:0]     dec_r, dec_a, dec_b;
   logic [7:0]                dec_cnt;
   logic                      unused_ins_bits;

   assign dec_op          = ins_data[63 -: OPCODE_WIDTH];
   assign dec_r           = ins_data[59 -: ADDR_WIDTH];
   assign dec_a           = ins_data[49 -: ADDR_WIDTH];
   assign dec_b           = ins_data[39 -: ADDR_WIDTH];
   assign dec_cnt         = ins_data[29:22];
   assign unused_ins_bits = ^{ins_data[60], ins_data[21:0]};

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      cnt_d         = cnt_q;
      r_f_d         = r_f_q;
      is_dot_d      = is_dot_q;
      last_d        = last_q;
      a_addr_d      = a_addr_q;
      b_addr_d      = b_addr_q;
      r_addr_d      = r_addr_q;
      pe_op_d       = pe_op_q;
      pc_overflow_d = pc_overflow_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               pc_d          = '0;
               pc_overflow_d = 1'b0;
               state_d       = S_FETCH;
            end
         end
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            r_f_d    = dec_r;
            is_dot_d = 1'b0;
            last_d   = (pc_q == PC_LAST);
            // Operand addresses load here so they are stable for the whole EXEC/DOT phase.
            case (dec_op)
               OP_HALT: state_d = S_DONE;
               OP_ADD, OP_SUB, OP_MUL: begin
                  pc_d     = pc_q + 1'b1;
                  a_addr_d = dec_a;
                  b_addr_d = dec_b;
                  if (dec_op == OP_ADD)      pe_op_d = 2'b00;
                  else if (dec_op == OP_SUB) pe_op_d = 2'b01;
                  else                       pe_op_d = 2'b10;
                  state_d  = S_EXEC;
               end
               OP_DOT: begin
                  pc_d     = pc_q + 1'b1;
                  a_addr_d = dec_a;
                  b_addr_d = dec_b;
                  cnt_d    = (dec_cnt == 8'd0) ? 8'd1 : dec_cnt;
                  is_dot_d = 1'b1;
                  state_d  = S_DOT;
               end
               default: begin
                  pc_d = pc_q + 1'b1;
                  if (pc_q == PC_LAST) begin
                     pc_overflow_d = 1'b1;
                     state_d       = S_DONE;
                  end else begin
                     state_d = S_FETCH;
                  end
               end
            endcase
         end
         S_EXEC: begin
            r_addr_d = r_f_q;
            state_d  = S_WRITE;
         end
         S_DOT: begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q <= 8'd1) begin
               r_addr_d = r_f_q;
               state_d  = S_WRITE;
            end
         end
         S_WRITE: begin
            // An instruction decoded at the top address finishes, then the program stops.
            if (last_q) begin
               pc_overflow_d = 1'b1;
               state_d       = S_DONE;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q       <= S_IDLE;
         pc_q          <= '0;
         cnt_q         <= '0;
         r_f_q         <= '0;
         is_dot_q      <= 1'b0;
         last_q        <= 1'b0;
         a_addr_q      <= '0;
         b_addr_q      <= '0;
         r_addr_q      <= '0;
         pe_op_q       <= '0;
         pc_overflow_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         cnt_q         <= cnt_d;
         r_f_q         <= r_f_d;
         is_dot_q      <= is_dot_d;
         last_q        <= last_d;
         a_addr_q      <= a_addr_d;
         b_addr_q      <= b_addr_d;
         r_addr_q      <= r_addr_d;
         pe_op_q       <= pe_op_d;
         pc_overflow_q <= pc_overflow_d;
      end
   end

   assign ins_addr    = pc_q;
   assign a_addr      = a_addr_q;
   assign b_addr      = b_addr_q;
   assign r_addr      = r_addr_q;
   assign pe_op       = pe_op_q;
   assign pc_overflow = pc_overflow_q;
   assign write_en    = (state_q == S_WRITE);
   assign r_select    = (state_q == S_WRITE) && is_dot_q;
   assign dot_prod_en = (state_q == S_DOT);
   assign shift       = (state_q == S_DOT);
   assign done        = (state_q == S_DONE);
   assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_simd_issue_ctrl.sv
// Directed bench for simd_issue_ctrl: small programs in a modelled instruction
// memory, write addresses scored against an expected queue.
module tb_simd_issue_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start = 1'b0;
   logic [63:0] ins_data = '0;
   logic [7:0]  ins_addr;
   logic [9:0]  a_addr, b_addr, r_addr;
   logic [1:0]  pe_op;
   logic        dot_prod_en, shift, write_en, r_select, busy, done, pc_overflow;
   logic [2:0]  dbg_state;

   logic [63:0] mem [256];
   logic [9:0]  exp_q[$];

   int n_checks = 0;
   int n_err    = 0;

   // Observations from the last program run
   int         done_cyc, n_write, n_shift, n_dot, max_run, n_exec, max_pc;
   logic [9:0] exec_a, exec_b, dot_a, dot_b;
   logic [1:0] exec_op;
   logic       w_sel, ovf_at_done, ovf_at_c1, busy_after, done_after;

   localparam logic [2:0] OP_NOP = 3'b000, OP_ADD = 3'b001, OP_SUB = 3'b010,
                          OP_MUL = 3'b011, OP_DOT = 3'b100, OP_HALT = 3'b111;

   simd_issue_ctrl dut (
      .clk(clk), .rstn(rstn), .start(start), .ins_data(ins_data),
      .ins_addr(ins_addr), .a_addr(a_addr), .b_addr(b_addr), .r_addr(r_addr),
      .pe_op(pe_op), .dot_prod_en(dot_prod_en), .shift(shift),
      .write_en(write_en), .r_select(r_select), .busy(busy), .done(done),
      .pc_overflow(pc_overflow), .dbg_state(dbg_state)
   );

   // clock / reset, instruction memory with one-cycle read latency
   always #5 clk = ~clk;
   always @(posedge clk) ins_data <= mem[ins_addr];

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ins(input logic [2:0] op, input int r, input int a,
                                       input int b, input int c);
      logic [63:0] w;
      w = '0;
      w[63:61] = op;
      w[59:50] = r[9:0];
      w[49:40] = a[9:0];
      w[39:30] = b[9:0];
      w[29:22] = c[7:0];
      return w;
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = '0;
   endtask

   // Pulses start, watches outputs each cycle until done (bounded), scoring writes.
   task automatic run_prog(input int extra_start);
      int cyc;
      int run;
      done_cyc = -1; n_write = 0; n_shift = 0; n_dot = 0; max_run = 0; n_exec = 0;
      max_pc = 0; exec_a = '0; exec_b = '0; exec_op = '0; dot_a = '0; dot_b = '0;
      w_sel = 1'b0; ovf_at_done = 1'b0; ovf_at_c1 = 1'b1; run = 0;
      start = 1'b1;
      @(negedge clk);
      cyc = 1;
      while (cyc <= 2000) begin
         start = (extra_start != 0 && cyc == extra_start);
         if (cyc == 1) ovf_at_c1 = pc_overflow;
         if (int'(ins_addr) > max_pc) max_pc = int'(ins_addr);
         if (dbg_state == 3'd3) begin
            n_exec++; exec_a = a_addr; exec_b = b_addr; exec_op = pe_op;
         end
         if (shift) begin
            n_shift++; run++; dot_a = a_addr; dot_b = b_addr;
            if (run > max_run) max_run = run;
         end else begin
            run = 0;
         end
         if (dot_prod_en) n_dot++;
         if (write_en) begin
            n_write++;
            w_sel = r_select;
            if (exp_q.size() == 0) check("unexpected write", 1, 0);
            else check("write r_addr", r_addr, exp_q.pop_front());
         end
         if (done) begin
            done_cyc = cyc;
            ovf_at_done = pc_overflow;
            break;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      if (done_cyc < 0) check("done timeout", 0, 1);
      check("writes left in queue", exp_q.size(), 0);
      exp_q.delete();
      @(negedge clk);
      busy_after = busy;
      done_after = done;
   endtask

   initial begin
      int waited;
      clear_mem();
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      check("rst busy", busy, 0);
      check("rst state", dbg_state, 0);
      check("rst write_en", write_en, 0);
      check("rst done", done, 0);
      check("rst ins_addr", ins_addr, 0);
      check("rst a_addr", a_addr, 0);
      check("rst pc_overflow", pc_overflow, 0);
      rstn = 1'b1;
      @(negedge clk);
      check("idle busy", busy, 0);

      // ADD then HALT
      mem[0] = ins(OP_ADD, 5, 1, 2, 0);
      mem[1] = ins(OP_HALT, 0, 0, 0, 0);
      exp_q.push_back(10'd5);
      run_prog(0);
      check("add exec a", exec_a, 1);
      check("add exec b", exec_b, 2);
      check("add pe_op", exec_op, 2'b00);
      check("add exec cycles", n_exec, 1);
      check("add writes", n_write, 1);
      check("add r_select", w_sel, 0);
      check("add done cycle", done_cyc, 7);
      check("add busy after", busy_after, 0);
      check("add done width", done_after, 0);

      // SUB, MUL, HALT
      clear_mem();
      mem[0] = ins(OP_SUB, 3, 4, 5, 0);
      mem[1] = ins(OP_MUL, 7, 8, 9, 0);
      mem[2] = ins(OP_HALT, 0, 0, 0, 0);
      exp_q.push_back(10'd3);
      exp_q.push_back(10'd7);
      run_prog(0);
      check("mul pe_op", exec_op, 2'b10);
      check("mul exec a", exec_a, 8);
      check("submul writes", n_write, 2);
      check("submul done cycle", done_cyc, 11);

      // DOT cnt=4
      clear_mem();
      mem[0] = ins(OP_DOT, 9, 0, 16, 4);
      mem[1] = ins(OP_HALT, 0, 0, 0, 0);
      exp_q.push_back(10'd9);
      run_prog(0);
      check("dot4 shifts", n_shift, 4);
      check("dot4 run", max_run, 4);
      check("dot4 acc", n_dot, 4);
      check("dot4 a", dot_a, 0);
      check("dot4 b", dot_b, 16);
      check("dot4 writes", n_write, 1);
      check("dot4 r_select", w_sel, 1);
      check("dot4 done cycle", done_cyc, 10);

      // DOT cnt=0 acts as 1
      clear_mem();
      mem[0] = ins(OP_DOT, 11, 3, 4, 0);
      mem[1] = ins(OP_HALT, 0, 0, 0, 0);
      exp_q.push_back(10'd11);
      run_prog(0);
      check("dot0 shifts", n_shift, 1);
      check("dot0 writes", n_write, 1);
      check("dot0 done cycle", done_cyc, 7);

      // Reserved opcodes and NOP; pe_op keeps the MUL select
      clear_mem();
      mem[0] = ins(3'b101, 1, 1, 1, 3);
      mem[1] = ins(3'b110, 2, 2, 2, 3);
      mem[2] = ins(OP_NOP, 3, 3, 3, 3);
      mem[3] = ins(OP_HALT, 0, 0, 0, 0);
      run_prog(0);
      check("nop writes", n_write, 0);
      check("nop shifts", n_shift, 0);
      check("nop exec", n_exec, 0);
      check("nop pe_op held", pe_op, 2'b10);
      check("nop done cycle", done_cyc, 9);

      // start while busy is ignored
      clear_mem();
      mem[4] = ins(OP_HALT, 0, 0, 0, 0);
      run_prog(4);
      check("busy start done cycle", done_cyc, 11);
      check("busy start max pc", max_pc, 4);

      // all NOP: pc runs off the end
      clear_mem();
      run_prog(0);
      check("ovf max pc", max_pc, 255);
      check("ovf done cycle", done_cyc, 513);
      check("ovf flag at done", ovf_at_done, 1);
      check("ovf sticky idle", pc_overflow, 1);
      mem[0] = ins(OP_HALT, 0, 0, 0, 0);
      run_prog(0);
      check("ovf cleared by start", ovf_at_c1, 0);
      check("halt only done cycle", done_cyc, 3);
      check("halt at 0 no ovf", ovf_at_done, 0);

      // ADD at the last address completes, then overflow
      clear_mem();
      mem[255] = ins(OP_ADD, 4, 6, 7, 0);
      exp_q.push_back(10'd4);
      run_prog(0);
      check("last add writes", n_write, 1);
      check("last add exec a", exec_a, 6);
      check("last add done cycle", done_cyc, 515);
      check("last add ovf", ovf_at_done, 1);

      // reset during DOT counting
      clear_mem();
      mem[0] = ins(OP_DOT, 1, 2, 3, 10);
      mem[1] = ins(OP_HALT, 0, 0, 0, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waited = 0;
      while (!shift && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check("dot reached", shift, 1);
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      check("rst dot shift", shift, 0);
      check("rst dot acc", dot_prod_en, 0);
      check("rst dot busy", busy, 0);
      check("rst dot write", write_en, 0);
      check("rst dot pc", ins_addr, 0);
      rstn = 1'b1;
      @(negedge clk);
      check("post rst write", write_en, 0);
      check("post rst state", dbg_state, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
